// File: rtl/big_core_fabric_out_fifo.sv
// Egress FIFO between the big core tile fabric output and the fabric router; drops and counts overflow.
// Optional same-cycle bypass when idle: define BIG_CORE_FABRIC_OUT_BYPASS_EN.
package big_core_fabric_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] payload;
    } t_tile_trans;
endpackage

module big_core_fabric_out_fifo
    import big_core_fabric_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int OVF_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   InFabricValidQ505H,
    input  t_tile_trans            InFabricQ505H,
    output logic                   OutFabricValid,
    output t_tile_trans            OutFabric,
    input  logic                   OutFabricReady,
    output logic                   Empty,
    output logic                   Full,
    output logic                   AlmostFull,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    output logic [OVF_CNT_W-1:0]   OverflowCnt,
    input  logic                   ClrOverflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];

    t_tile_trans storage [DEPTH];

    logic [AW:0]          wrPtrReg, wrPtrNext;
    logic [AW:0]          rdPtrReg, rdPtrNext;
    logic [AW:0]          occupancy;
    logic                 memPop, push, drop, bypassTake;
    logic                 overflowReg, overflowNext;
    logic [OVF_CNT_W-1:0] ovfCntReg, ovfCntNext;

    assign occupancy  = wrPtrReg - rdPtrReg;
    assign Empty      = (wrPtrReg == rdPtrReg);
    // Same slot index but opposite lap bit means every slot is occupied.
    assign Full       = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                        (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
    assign AlmostFull = (occupancy >= AF_THRESH);
    assign Count      = occupancy;

    assign memPop = !Empty && OutFabricReady;

`ifdef BIG_CORE_FABRIC_OUT_BYPASS_EN
    // Idle FIFO: present the incoming transaction directly; consume it without storing if taken.
    assign bypassTake     = Empty && InFabricValidQ505H && OutFabricReady;
    assign OutFabricValid = !Empty || InFabricValidQ505H;
    assign OutFabric      = Empty ? InFabricQ505H : storage[rdPtrReg[AW-1:0]];
`else
    assign bypassTake     = 1'b0;
    assign OutFabricValid = !Empty;
    assign OutFabric      = storage[rdPtrReg[AW-1:0]];
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the new entry.
    assign push = InFabricValidQ505H && (!Full || memPop) && !bypassTake;
    assign drop = InFabricValidQ505H && Full && !memPop;

    always_comb begin
        wrPtrNext    = wrPtrReg;
        rdPtrNext    = rdPtrReg;
        overflowNext = overflowReg;
        ovfCntNext   = ovfCntReg;
        if (push) begin
            wrPtrNext = wrPtrReg + 1'b1;
        end
        if (memPop) begin
            rdPtrNext = rdPtrReg + 1'b1;
        end
        if (ClrOverflow) begin
            overflowNext = drop;
            ovfCntNext   = drop ? OVF_CNT_W'(1) : '0;
        end else if (drop) begin
            overflowNext = 1'b1;
            if (ovfCntReg != '1) begin
                ovfCntNext = ovfCntReg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            overflowReg <= 1'b0;
            ovfCntReg   <= '0;
        end else begin
            wrPtrReg    <= wrPtrNext;
            rdPtrReg    <= rdPtrNext;
            overflowReg <= overflowNext;
            ovfCntReg   <= ovfCntNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            storage[wrPtrReg[AW-1:0]] <= InFabricQ505H;
        end
    end

    assign Overflow    = overflowReg;
    assign OverflowCnt = ovfCntReg;
endmodule

// File: tb/tb_big_core_fabric_out_fifo.sv
// Scoreboard bench for big_core_fabric_out_fifo: a negedge monitor tracks a reference queue,
// scenario tasks check the flag behaviour at specific cycles.
`timescale 1ns/1ps
module tb_big_core_fabric_out_fifo;
    import big_core_fabric_pkg::*;

    localparam int DEPTH     = 4;
    localparam int AF_LEVEL  = 3;
    localparam int OVF_CNT_W = 4;
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

    logic                 Clk = 1'b0;
    logic                 RstN = 1'b0;
    logic                 InValid = 1'b0;
    t_tile_trans          InData = '0;
    logic                 Ready = 1'b0;
    logic                 Clr = 1'b0;
    logic                 OutValid;
    t_tile_trans          OutData;
    logic                 Empty, Full, AlmostFull, Overflow;
    logic [2:0]           Count;
    logic [OVF_CNT_W-1:0] OverflowCnt;

    int nVec  = 0;
    int nFail = 0;

    t_tile_trans             sbQ[$];
    logic                    mdlOvf = 1'b0;
    logic [OVF_CNT_W-1:0]    mdlCnt = '0;

    big_core_fabric_out_fifo #(
        .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .OVF_CNT_W(OVF_CNT_W)
    ) dut (
        .Clk(Clk), .RstN(RstN),
        .InFabricValidQ505H(InValid), .InFabricQ505H(InData),
        .OutFabricValid(OutValid), .OutFabric(OutData), .OutFabricReady(Ready),
        .Empty(Empty), .Full(Full), .AlmostFull(AlmostFull), .Count(Count),
        .Overflow(Overflow), .OverflowCnt(OverflowCnt), .ClrOverflow(Clr)
    );

    always #5 Clk = ~Clk;

    function automatic t_tile_trans mk(input int i);
        t_tile_trans t;
        t.tag     = 8'(i);
        t.payload = {16'hC0DE, 16'(i * 37)};
        return t;
    endfunction

    // Reference model: evaluated at negedge on the inputs that the next rising edge will see.
    always @(negedge Clk) begin
        int          n;
        logic        memPop, bypassTake, push, drop, expValid;
        t_tile_trans expData;
        if (!RstN) begin
            sbQ.delete();
            mdlOvf = 1'b0;
            mdlCnt = '0;
        end else begin
            n      = sbQ.size();
            memPop = (n > 0) && Ready;
`ifdef BIG_CORE_FABRIC_OUT_BYPASS_EN
            bypassTake = (n == 0) && InValid && Ready;
            expValid   = (n > 0) || InValid;
`else
            bypassTake = 1'b0;
            expValid   = (n > 0);
`endif
            push = InValid && ((n < DEPTH) || memPop) && !bypassTake;
            drop = InValid && (n == DEPTH) && !memPop;

            nVec++;
            if (OutValid !== expValid) begin
                nFail++;
                $display("FAIL mon_valid t=%0t: got %b want %b", $time, OutValid, expValid);
            end
            nVec++;
            if (Count !== 3'(n)) begin
                nFail++;
                $display("FAIL mon_count t=%0t: got %0d want %0d", $time, Count, n);
            end
            nVec++;
            if (Overflow !== mdlOvf || OverflowCnt !== mdlCnt) begin
                nFail++;
                $display("FAIL mon_ovf t=%0t: got %b/%0d want %b/%0d",
                         $time, Overflow, OverflowCnt, mdlOvf, mdlCnt);
            end

            if (push || bypassTake) sbQ.push_back(InData);
            if (memPop || bypassTake) begin
                expData = sbQ.pop_front();
                nVec++;
                if (OutData !== expData) begin
                    nFail++;
                    $display("FAIL mon_data t=%0t: got %h want %h", $time, OutData, expData);
                end else begin
                    $display("pop t=%0t tag=%h payload=%h", $time, OutData.tag, OutData.payload);
                end
            end
            if (drop) $display("drop t=%0t tag=%h", $time, InData.tag);

            if (Clr) begin
                mdlOvf = drop;
                mdlCnt = drop ? OVF_CNT_W'(1) : '0;
            end else if (drop) begin
                mdlOvf = 1'b1;
                if (mdlCnt != CNT_MAX) mdlCnt = mdlCnt + 1'b1;
            end
        end
    end

    // Apply one cycle of inputs just after a rising edge; return at the following negedge.
    task automatic tick(input logic v, input t_tile_trans d, input logic r, input logic c);
        @(posedge Clk);
        #1;
        InValid = v;
        InData  = d;
        Ready   = r;
        Clr     = c;
        @(negedge Clk);
    endtask

    task automatic drain();
        repeat (DEPTH + 2) tick(1'b0, '0, 1'b1, 1'b0);
        nVec++;
        if (Empty !== 1'b1 || Count !== 3'd0) begin
            nFail++;
            $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", Empty, Count);
        end
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, mk(base + i), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        nVec++;
        if ({Empty, Full, AlmostFull, OutValid, Overflow} !== 5'b10000 ||
            Count !== 3'd0 || OverflowCnt !== '0) begin
            nFail++;
            $display("FAIL reset_state: got E%b F%b AF%b V%b O%b cnt=%0d ovf=%0d want E1 F0 AF0 V0 O0 0 0",
                     Empty, Full, AlmostFull, OutValid, Overflow, Count, OverflowCnt);
        end
        @(posedge Clk);
        #2;
        RstN = 1'b1;
    endtask

    task automatic test_basic();
        tick(1'b1, mk(8'hA0), 1'b1, 1'b0);
`ifdef BIG_CORE_FABRIC_OUT_BYPASS_EN
        nVec++;
        if (OutValid !== 1'b1 || OutData !== mk(8'hA0)) begin
            nFail++;
            $display("FAIL basic_bypass: got v=%b %h want 1 %h", OutValid, OutData, mk(8'hA0));
        end
        tick(1'b0, '0, 1'b1, 1'b0);
`else
        nVec++;
        if (OutValid !== 1'b0) begin
            nFail++;
            $display("FAIL basic_push_cycle_valid: got %b want 0", OutValid);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        nVec++;
        if (OutValid !== 1'b1 || OutData !== mk(8'hA0) || Count !== 3'd1) begin
            nFail++;
            $display("FAIL basic_latency: got v=%b %h cnt=%0d want 1 %h 1",
                     OutValid, OutData, Count, mk(8'hA0));
        end
        tick(1'b0, '0, 1'b1, 1'b0);
`endif
        nVec++;
        if (Empty !== 1'b1 || Count !== 3'd0) begin
            nFail++;
            $display("FAIL basic_empty: got empty=%b count=%0d want 1/0", Empty, Count);
        end
    endtask

    task automatic test_fill_overflow();
        tick(1'b1, mk(1), 1'b0, 1'b0);
        tick(1'b1, mk(2), 1'b0, 1'b0);
        tick(1'b1, mk(3), 1'b0, 1'b0);
        nVec++;
        if (Count !== 3'd2 || AlmostFull !== 1'b0) begin
            nFail++;
            $display("FAIL fill_af_below: got cnt=%0d af=%b want 2/0", Count, AlmostFull);
        end
        tick(1'b1, mk(4), 1'b0, 1'b0);
        nVec++;
        if (Count !== 3'd3 || AlmostFull !== 1'b1 || Full !== 1'b0) begin
            nFail++;
            $display("FAIL fill_af_at: got cnt=%0d af=%b full=%b want 3/1/0", Count, AlmostFull, Full);
        end
        tick(1'b1, mk(5), 1'b0, 1'b0);
        nVec++;
        if (Count !== 3'd4 || Full !== 1'b1 || AlmostFull !== 1'b1) begin
            nFail++;
            $display("FAIL fill_full: got cnt=%0d full=%b af=%b want 4/1/1", Count, Full, AlmostFull);
        end
        tick(1'b1, mk(6), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Overflow !== 1'b1 || OverflowCnt !== 4'd2 || Count !== 3'd4) begin
            nFail++;
            $display("FAIL ovf_two_drops: got o=%b cnt=%0d occ=%0d want 1/2/4", Overflow, OverflowCnt, Count);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Overflow !== 1'b0 || OverflowCnt !== 4'd0) begin
            nFail++;
            $display("FAIL ovf_clear: got o=%b cnt=%0d want 0/0", Overflow, OverflowCnt);
        end
        drain();
    endtask

    task automatic test_full_push_pop();
        fill(16);
        tick(1'b1, mk(8'h47), 1'b1, 1'b0);
        nVec++;
        if (Full !== 1'b1) begin
            nFail++;
            $display("FAIL fpp_full_before: got %b want 1", Full);
        end
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0) begin
            nFail++;
            $display("FAIL fpp_no_drop: got cnt=%0d full=%b o=%b want 4/1/0", Count, Full, Overflow);
        end
        drain();
    endtask

    task automatic test_saturate();
        fill(32);
        for (int i = 0; i < 20; i++) tick(1'b1, mk(64 + i), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Overflow !== 1'b1 || OverflowCnt !== CNT_MAX) begin
            nFail++;
            $display("FAIL sat_cnt: got o=%b cnt=%0d want 1/%0d", Overflow, OverflowCnt, CNT_MAX);
        end
        tick(1'b1, mk(99), 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Overflow !== 1'b1 || OverflowCnt !== 4'd1) begin
            nFail++;
            $display("FAIL clr_with_drop: got o=%b cnt=%0d want 1/1", Overflow, OverflowCnt);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_wrap();
        int maxCount = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, mk(128 + i), logic'(i % 2 == 0), 1'b0);
            if (int'(Count) > maxCount) maxCount = int'(Count);
            tick(1'b0, '0, 1'b1, 1'b0);
            if (int'(Count) > maxCount) maxCount = int'(Count);
        end
        nVec++;
        if (maxCount > DEPTH || Overflow !== 1'b0) begin
            nFail++;
            $display("FAIL wrap_bounds: got max=%0d o=%b want <=%0d/0", maxCount, Overflow, DEPTH);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, mk(200 + i), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        nVec++;
        if (Count !== 3'd3) begin
            nFail++;
            $display("FAIL rstmid_queued: got %0d want 3", Count);
        end
        @(posedge Clk);
        #3;
        RstN = 1'b0;
        #1;
        nVec++;
        if (OutValid !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1) begin
            nFail++;
            $display("FAIL rstmid_async: got v=%b cnt=%0d e=%b want 0/0/1", OutValid, Count, Empty);
        end
        @(posedge Clk);
        #2;
        RstN = 1'b1;
        tick(1'b1, mk(8'hE8), 1'b1, 1'b0);
`ifdef BIG_CORE_FABRIC_OUT_BYPASS_EN
        nVec++;
        if (OutValid !== 1'b1 || OutData !== mk(8'hE8) || Count !== 3'd0) begin
            nFail++;
            $display("FAIL rstmid_bypass: got v=%b %h cnt=%0d want 1 %h 0",
                     OutValid, OutData, Count, mk(8'hE8));
        end
`else
        nVec++;
        if (OutValid !== 1'b0) begin
            nFail++;
            $display("FAIL rstmid_push_valid: got %b want 0", OutValid);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        nVec++;
        if (OutValid !== 1'b1 || OutData !== mk(8'hE8)) begin
            nFail++;
            $display("FAIL rstmid_first: got v=%b %h want 1 %h", OutValid, OutData, mk(8'hE8));
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_push_pop();
        test_saturate();
        test_wrap();
        test_reset_mid();
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL sb_leftover: got %0d entries want 0", sbQ.size());
        end
        nVec++;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule

// File: doc/big_core_fabric_out_fifo.md
Name: big_core_fabric_out_fifo

Overview:
- Egress buffer directly downstream of the big core tile's fabric output (OutFabricValidQ505H / OutFabricQ505H).
- The tile issues transactions with no backpressure. This block absorbs them into a FIFO and presents them to the fabric router over a valid/ready handshake.
- Drops and counts transactions that arrive while the FIFO is full, so software or debug can detect lost fabric traffic.

Parameters:
- DEPTH, 4, number of t_tile_trans entries; power of two, >= 2.
- AF_LEVEL, 3, occupancy at or above which AlmostFull asserts; 1..DEPTH.
- OVF_CNT_W, 16, width of the saturating overflow counter.

Ports:
- Clk  in  1  core clock.
- RstN  in  1  asynchronous active-low reset.
- InFabricValidQ505H  in  1  transaction valid from the tile.
- InFabricQ505H  in  t_tile_trans  transaction from the tile.
- OutFabricValid  out  1  head entry valid toward the fabric.
- OutFabric  out  t_tile_trans  head entry toward the fabric.
- OutFabricReady  in  1  fabric accepts the head this cycle.
- Empty  out  1  occupancy == 0.
- Full  out  1  occupancy == DEPTH.
- AlmostFull  out  1  occupancy >= AF_LEVEL.
- Count  out  $clog2(DEPTH)+1  current occupancy.
- Overflow  out  1  sticky; set on the first dropped transaction.
- OverflowCnt  out  OVF_CNT_W  number of dropped transactions, saturating.
- ClrOverflow  in  1  synchronous clear of Overflow and OverflowCnt.

Behaviour:
- Reset, asynchronous on RstN low:
  - read/write pointers = 0, Count = 0
  - Empty = 1, Full = 0, AlmostFull = 0, OutFabricValid = 0
  - Overflow = 0, OverflowCnt = 0
  - storage contents are don't-care
  - OutFabric is driven from storage, so its value is don't-care while OutFabricValid = 0
- Reset asserted mid-operation discards all queued entries. No partial transaction is emitted after RstN deasserts.
- Storage:
  - register array of DEPTH x t_tile_trans
  - write and read pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty
  - pointers wrap naturally modulo 2*DEPTH
- Pop = OutFabricValid && OutFabricReady. The read pointer advances on the next Clk rising edge.
- Push = InFabricValidQ505H && (!Full || Pop). The entry is written at the write pointer on the rising edge and the write pointer advances.
- Drop = InFabricValidQ505H && Full && !Pop. The entry is discarded and the pointers are unchanged.
- OutFabricValid = !Empty. OutFabric = storage[read pointer] (first-word fall-through from registers).
- Latency: an entry pushed at edge N is visible on OutFabricValid/OutFabric in the cycle following edge N, i.e. one cycle.
- Count(next):
  - Count + 1 on push only
  - Count − 1 on pop only
  - unchanged on push+pop or on neither
- Full + pop + push in the same cycle: both occur, Count stays DEPTH, and no drop is recorded.
- Empty + push: OutFabricValid stays 0 in the push cycle (no bypass unless the optional feature is enabled).
- OutFabricReady while Empty: no effect.
- Ordering: strict FIFO; transactions are never reordered or duplicated.
- Overflow counter:
  - each Drop increments OverflowCnt, saturating at all-ones
  - Overflow is set on any Drop and stays set
  - ClrOverflow clears both on the next edge
  - if ClrOverflow coincides with a Drop, the result is Overflow = 1, OverflowCnt = 1
- Flags Empty, Full, AlmostFull and Count are derived from the registered pointers. No combinational path exists from InFabricValidQ505H to any output.

Optional Feature:
- Macro: BIG_CORE_FABRIC_OUT_BYPASS_EN.
- When defined:
  - if Empty && InFabricValidQ505H, then OutFabricValid = 1 and OutFabric = InFabricQ505H combinationally in the same cycle
  - if OutFabricReady is also 1, the entry is consumed without being written (pointers and Count unchanged)
  - otherwise the entry is pushed normally
  - zero-latency path when idle
- When undefined: no combinational input-to-output path; minimum latency is 1 cycle as above.

Test Plan:
- Basic flow, DEPTH=4, OutFabricReady=1:
  - stimulus: push A at cycle 0
  - response: OutFabricValid=1 with OutFabric=A at cycle 1, Empty=1 at cycle 2, Count back to 0
- Fill and order, OutFabricReady=0:
  - stimulus: push A,B,C,D on consecutive cycles
  - response: Count reaches 4, Full=1, AlmostFull=1 from Count=3
  - then raise OutFabricReady: outputs A,B,C,D in order, Empty=1 after the 4th pop
- Overflow, FIFO full, ready=0:
  - stimulus: push E,F
  - response: both dropped, Overflow=1, OverflowCnt=2, contents still A..D
  - then ClrOverflow=1 for one cycle: Overflow=0, OverflowCnt=0
- Simultaneous push/pop at full, ready=1:
  - stimulus: push G in the same cycle as popping the head
  - response: Count stays 4, no drop, G emerges after the 3 older entries
- Wrap-around:
  - stimulus: 10 push/pop pairs with ready toggling 1,0,1,0
  - response: output sequence identical to input sequence, Count never exceeds 4, no drops
- Reset mid-operation:
  - stimulus: 3 entries queued, RstN=0 asynchronously mid-cycle
  - response: OutFabricValid=0, Count=0, Empty=1 immediately
  - after release, pushing H yields H first
  - with BIG_CORE_FABRIC_OUT_BYPASS_EN: on empty with ready=1, H appears in the same cycle and Count stays 0
